dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (`data_memory`).
- Requester 0 is the pipeline MEM stage (cpu_*). Requester 1 is the debug/program loader port (dbg_*).
- Serialises accesses, drives the memory's MemWrite/MemRead/address/write_data, captures read_data, and returns ack, data and error to the winner.
- Also produces a stall for the pipeline hazard unit.

Parameters:
- DATA_W, 32, data width of all data buses.
- ADDR_W, 32, byte-address width.
- MEM_BYTES, 1024, size of the backing memory in bytes; legal range is 0 .. MEM_BYTES-4.
- FIXED_PRIO, 0, 0 = round-robin; 1 = cpu always wins ties.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- cpu_req  input  1  cpu access request; held until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  byte address
- cpu_wdata  input  DATA_W  write data
- cpu_rdata  output  DATA_W  read data, valid while cpu_ack=1
- cpu_ack  output  1  one-cycle completion pulse
- cpu_err  output  1  error flag, valid while cpu_ack=1
- cpu_stall  output  1  cpu_req & ~cpu_ack (combinational)
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack, dbg_err: same directions, widths and meanings as the cpu_* ports
- mem_MemWrite  output  1  to memory MemWrite
- mem_MemRead  output  1  to memory MemRead
- mem_address  output  ADDR_W  to memory address
- mem_write_data  output  DATA_W  to memory write_data
- mem_read_data  input  DATA_W  from memory read_data (combinational read)
- busy  output  1  1 when state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active low.
- Reset values: state=IDLE; every output 0 (rdata, ack, err, mem_* strobes, address, write_data, busy); last_grant=dbg, so the cpu wins the first tie.
- Memory model: writes commit on the rising clk edge while MemWrite=1; read_data is combinational from address while MemRead=1.

States:
- IDLE
  - If neither req is set: stay.
  - Else select the winner. If only one req is set, that one wins. If both are set: with FIXED_PRIO=1 the cpu wins; otherwise the requester that is not last_grant wins.
  - Latch owner, we, addr and wdata into internal registers.
  - Address is legal when addr[1:0]==0 and addr <= MEM_BYTES-4.
  - Legal address: go to ACCESS. Illegal address: set err_r=1 and go straight to DONE; no memory strobe is ever issued.
- ACCESS (exactly 1 cycle)
  - mem_address=addr_r, mem_write_data=wdata_r, mem_MemWrite=we_r, mem_MemRead=~we_r.
  - At the closing edge: a write commits, or mem_read_data is registered into rdata_r.
  - Go to DONE.
- DONE (exactly 1 cycle)
  - Owner's ack=1; owner's rdata=rdata_r (0 for writes and for errors); owner's err=err_r.
  - The non-owner's ack, err and rdata stay 0.
  - mem_MemWrite=mem_MemRead=0.
  - At the closing edge: last_grant=owner, clear err_r, go to IDLE.

Handshake and latency:
- A requester holds req, we, addr and wdata stable until it sees ack.
- It deasserts req, or presents a new request, on the edge that ends the ack cycle.
- IDLE samples req only after DONE, so there is no double service.
- Latency from req sampled in IDLE to ack: 2 cycles for a legal access, 1 cycle for an error.
- Peak throughput: one access per 3 cycles.

Other rules:
- Inputs that change while the owner is in ACCESS or DONE are ignored, because the latched copies are used.
- A loser's req stays pending and is granted in the next IDLE. Round-robin guarantees service within one competing transaction.
- Outside ACCESS: mem_address and mem_write_data hold their last values; both strobes are 0.
- Reset mid-operation: asserting rst_n=0 during ACCESS drops mem_MemWrite immediately, so the write is not guaranteed to commit. No ack is issued; state returns to IDLE.
- No arithmetic beyond the range compare, which uses ADDR_W-bit unsigned comparison.

Test Plan:
- Test 1: cpu write addr=0x0, wdata=0xDEADBEEF -> mem_MemWrite=1 for exactly 1 cycle with mem_address=0x0; cpu_ack 2 cycles after IDLE sample; cpu_err=0; cpu_stall=1 until ack.
- Test 2: cpu read addr=0x0 after Test 1 -> mem_MemRead=1 for 1 cycle; cpu_rdata=0xDEADBEEF with cpu_ack; dbg_ack stays 0.
- Test 3: cpu and dbg requests in the same cycle, repeated 4 times with FIXED_PRIO=0 -> grant order cpu, dbg, cpu, dbg. With FIXED_PRIO=1 -> cpu every time while cpu_req=1.
- Test 4: dbg write addr=0x4, wdata=0xCAFEBABE while cpu read addr=0x4 is pending -> dbg served first (last_grant=cpu); cpu later reads 0xCAFEBABE. A read of unwritten addr=0x8 returns 0.
- Test 5: cpu read addr=0x2 (misaligned), then cpu read addr=MEM_BYTES -> each gets cpu_ack with cpu_err=1 one cycle after sample and cpu_rdata=0; mem_MemRead and mem_MemWrite never asserted.
- Test 6: rst_n pulsed low during ACCESS of a dbg write to 0x10 -> all outputs 0 immediately; no dbg_ack; busy=0. After release, a cpu read of 0x10 completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester (cpu / debug) arbiter and sequencer in front of the single-port data memory.
// Each access runs IDLE -> ACCESS -> DONE; illegal addresses skip ACCESS and are acked with err.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_BYTES  = 1024,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_t            state, state_next;
  logic              owner_r;     // 1 = dbg owns the current transaction
  logic              last_grant;  // 1 = dbg was served last
  logic              we_r, err_r;
  logic [ADDR_W-1:0] addr_r, mem_addr_r;
  logic [DATA_W-1:0] wdata_r, mem_wdata_r, rdata_r;

  logic              any_req, grant_dbg, sel_we, addr_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_WORD);
  endfunction

  // Winner selection: a lone requester wins; ties go by FIXED_PRIO or round-robin.
  always_comb begin
    any_req   = cpu_req | dbg_req;
    grant_dbg = dbg_req && (!cpu_req || (FIXED_PRIO == 0 && !last_grant));
    sel_we    = grant_dbg ? dbg_we    : cpu_we;
    sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
    sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
    addr_ok   = addr_legal(sel_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = addr_ok ? ACCESS : DONE;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latched request copies; the memory bus registers only load on legal grants so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r     <= 1'b0;
      last_grant  <= 1'b1;
      we_r        <= 1'b0;
      err_r       <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      rdata_r     <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner_r <= grant_dbg;
          we_r    <= sel_we;
          addr_r  <= sel_addr;
          wdata_r <= sel_wdata;
          rdata_r <= '0;
          err_r   <= !addr_ok;
          if (addr_ok) begin
            mem_addr_r  <= sel_addr;
            mem_wdata_r <= sel_wdata;
          end
        end
        ACCESS: if (!we_r) rdata_r <= mem_read_data;
        DONE: begin
          last_grant <= owner_r;
          err_r      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_MemWrite   = 1'b0;
    mem_MemRead    = 1'b0;
    mem_address    = mem_addr_r;
    mem_write_data = mem_wdata_r;
    cpu_ack        = 1'b0;
    cpu_err        = 1'b0;
    cpu_rdata      = '0;
    dbg_ack        = 1'b0;
    dbg_err        = 1'b0;
    dbg_rdata      = '0;
    busy           = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_MemWrite = we_r;
        mem_MemRead  = !we_r;
      end
      DONE: begin
        if (owner_r) begin
          dbg_ack   = 1'b1;
          dbg_err   = err_r;
          dbg_rdata = rdata_r;
        end else begin
          cpu_ack   = 1'b1;
          cpu_err   = err_r;
          cpu_rdata = rdata_r;
        end
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

  // addr_r/wdata_r mirror the granted request for the whole transaction.
  logic unused_copy;
  assign unused_copy = ^{addr_r, wdata_r};

endmodule
